// File: rtl/jstk_scheduler.sv
// jstk_scheduler: time-shares one SPI joystick core between two joysticks.
// A free-running tick requests a poll round; each round runs ch0 then ch1.
// For each channel the core's slave-select and MISO are steered to that
// joystick and the core's dav handshake is run. The result is latched into
// that channel's registers.
//
// Core handshake: coredav is held high from START through WAIT to request one
// transaction. The core answers with a single-cycle coredavin pulse when the
// data on corexdata/coreydata/corebutton is valid. coredav drops in DONE and
// in SETUP so that the core returns to its idle state before the next request.
// A pulse seen outside WAIT is ignored.
module jstk_scheduler #(
  parameter int POLL_DIV = 24000,
  parameter int TIMEOUT  = 1023
) (
  input  logic        jstkclk,
  input  logic        jstkrst_n,
  input  logic        jstken,
  input  logic [3:0]  jstkledreq,
  output logic        coredav,
  input  logic        coredavin,
  output logic [1:0]  coreled,
  input  logic [9:0]  corexdata,
  input  logic [9:0]  coreydata,
  input  logic [2:0]  corebutton,
  input  logic        coress,
  output logic        coremiso,
  output logic [1:0]  jstkss,
  input  logic [1:0]  jstkmiso,
  output logic [19:0] jstkxdata,
  output logic [19:0] jstkydata,
  output logic [5:0]  jstkbutton,
  output logic [1:0]  jstkupd,
  output logic [1:0]  jstkto,
  output logic        jstkovr,
  output logic        jstkbusy,
  output logic [2:0]  jstkstate
);

  localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q;
  logic               ch_q;
  logic [TMR_W-1:0]   timer_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               ovr_q, ovr_d;
  logic               tick;
  logic               consume;
  logic               coredav_q;
  logic [1:0]         coreled_q;
  logic [19:0]        xdata_q, ydata_q;
  logic [5:0]         button_q;
  logic [1:0]         upd_q, to_q;

  // Tick generation and pending/overrun bookkeeping for the next state.
  always_comb begin
    tick    = (cnt_q == CNT_W'(POLL_DIV - 1));
    cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
    consume = (state_q == S_IDLE) && pend_q && jstken;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    if (!jstken) begin
      pend_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      if (consume) pend_d = 1'b0;
      // A tick landing on an already pending request is dropped and flagged.
      if (tick) begin
        if (pend_d) ovr_d  = 1'b1;
        else        pend_d = 1'b1;
      end
    end
  end

  // Poll-rate counter, pending request and sticky overrun flag.
  always_ff @(posedge jstkclk or negedge jstkrst_n) begin
    if (!jstkrst_n) begin
      cnt_q  <= '0;
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
    end
  end

  // Round sequencer with registered handshake, LED and result outputs.
  always_ff @(posedge jstkclk or negedge jstkrst_n) begin
    if (!jstkrst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= 1'b0;
      timer_q   <= '0;
      coredav_q <= 1'b0;
      coreled_q <= 2'b00;
      xdata_q   <= '0;
      ydata_q   <= '0;
      button_q  <= '0;
      upd_q     <= 2'b00;
      to_q      <= 2'b00;
    end else begin
      upd_q <= 2'b00;
      case (state_q)
        S_IDLE: begin
          if (consume) begin
            ch_q      <= 1'b0;
            coreled_q <= jstkledreq[1:0];
            state_q   <= S_SETUP;
          end
        end
        S_SETUP: begin
          coredav_q <= 1'b1;
          state_q   <= S_START;
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A response in the last timer cycle still counts as success.
          if (coredavin) begin
            if (ch_q) begin
              xdata_q[19:10] <= corexdata;
              ydata_q[19:10] <= coreydata;
              button_q[5:3]  <= corebutton;
            end else begin
              xdata_q[9:0]   <= corexdata;
              ydata_q[9:0]   <= coreydata;
              button_q[2:0]  <= corebutton;
            end
            to_q[ch_q]  <= 1'b0;
            upd_q[ch_q] <= 1'b1;
            coredav_q   <= 1'b0;
            state_q     <= S_DONE;
          end else if (timer_q == TMR_W'(TIMEOUT)) begin
            to_q[ch_q] <= 1'b1;
            coredav_q  <= 1'b0;
            state_q    <= S_DONE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DONE: begin
          // coreled changes only on entry to SETUP, so it is stable for the core.
          if (!ch_q && jstken) begin
            ch_q      <= 1'b1;
            coreled_q <= jstkledreq[3:2];
            state_q   <= S_SETUP;
          end else begin
            ch_q    <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          coredav_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  // Steer the core's slave-select and MISO to the active joystick.
  always_comb begin
    jstkss = 2'b11;
    if (state_q != S_IDLE) jstkss[ch_q] = coress;
    coremiso = jstkmiso[ch_q];
  end

  assign coredav    = coredav_q;
  assign coreled    = coreled_q;
  assign jstkxdata  = xdata_q;
  assign jstkydata  = ydata_q;
  assign jstkbutton = button_q;
  assign jstkupd    = upd_q;
  assign jstkto     = to_q;
  assign jstkovr    = ovr_q;
  assign jstkbusy   = (state_q != S_IDLE);
  assign jstkstate  = state_q;

endmodule

// File: tb/tb_jstk_scheduler.sv
// Testbench for jstk_scheduler: a behavioural joystick core answers each
// transaction after a fixed latency. Directed rounds cover data latching,
// timeout, LED steering, jstken drop, overrun and mid-transaction reset.
module tb_jstk_scheduler;

  localparam int LAT = 150;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance signals
  logic        jstken;
  logic [3:0]  jstkledreq;
  logic        coredav, coredavin, coress, coremiso;
  logic [1:0]  coreled, jstkss, jstkmiso, jstkupd, jstkto;
  logic [9:0]  corexdata, coreydata;
  logic [2:0]  corebutton, jstkstate;
  logic [19:0] jstkxdata, jstkydata;
  logic [5:0]  jstkbutton;
  logic        jstkovr, jstkbusy;

  // overrun instance signals
  logic        en2;
  logic        o_coredav, o_coremiso, o_ovr, o_busy;
  logic [1:0]  o_coreled, o_ss, o_upd, o_to;
  logic [19:0] o_x, o_y;
  logic [5:0]  o_b;
  logic [2:0]  o_state;

  jstk_scheduler #(.POLL_DIV(600), .TIMEOUT(200)) u_dut (
    .jstkclk(clk), .jstkrst_n(rst_n), .jstken(jstken), .jstkledreq(jstkledreq),
    .coredav(coredav), .coredavin(coredavin), .coreled(coreled),
    .corexdata(corexdata), .coreydata(coreydata), .corebutton(corebutton),
    .coress(coress), .coremiso(coremiso), .jstkss(jstkss), .jstkmiso(jstkmiso),
    .jstkxdata(jstkxdata), .jstkydata(jstkydata), .jstkbutton(jstkbutton),
    .jstkupd(jstkupd), .jstkto(jstkto), .jstkovr(jstkovr), .jstkbusy(jstkbusy),
    .jstkstate(jstkstate)
  );

  jstk_scheduler #(.POLL_DIV(40), .TIMEOUT(100)) u_ovr (
    .jstkclk(clk), .jstkrst_n(rst_n), .jstken(en2), .jstkledreq(4'b0000),
    .coredav(o_coredav), .coredavin(1'b0), .coreled(o_coreled),
    .corexdata(10'd0), .coreydata(10'd0), .corebutton(3'd0),
    .coress(1'b1), .coremiso(o_coremiso), .jstkss(o_ss), .jstkmiso(2'b00),
    .jstkxdata(o_x), .jstkydata(o_y), .jstkbutton(o_b),
    .jstkupd(o_upd), .jstkto(o_to), .jstkovr(o_ovr), .jstkbusy(o_busy),
    .jstkstate(o_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // core model and monitor state
  logic [1:0] resp_en;
  logic [9:0] x0_v, y0_v, x1_v, y1_v;
  logic [2:0] b0_v, b1_v;
  logic       m_ch;
  logic [1:0] exp_led;
  logic [2:0] prev_state;
  int lat_cnt, wait_cnt, last_wait;
  int ss_viol, miso_viol, led_viol;

  // Core model plus steering monitor, evaluated on the falling edge.
  initial begin
    coredavin = 1'b0; coress = 1'b1; jstkmiso = 2'b00;
    corexdata = '0; coreydata = '0; corebutton = '0;
    m_ch = 1'b0; exp_led = 2'b00; prev_state = S_IDLE;
    lat_cnt = 0; wait_cnt = 0; last_wait = 0;
    ss_viol = 0; miso_viol = 0; led_viol = 0;
    forever begin
      @(negedge clk);
      if (jstkstate == S_SETUP && prev_state == S_IDLE) m_ch = 1'b0;
      else if (jstkstate == S_SETUP && prev_state == S_DONE) m_ch = 1'b1;
      if (jstkstate == S_SETUP) exp_led = jstkledreq[2*m_ch +: 2];
      if (jstkstate == S_WAIT) wait_cnt++;
      else begin
        if (jstkstate == S_DONE) last_wait = wait_cnt;
        wait_cnt = 0;
      end
      if (jstkbusy) begin
        if (jstkss[!m_ch] !== 1'b1) ss_viol++;
        if (jstkss[m_ch] !== coress) ss_viol++;
        if (coremiso !== jstkmiso[m_ch]) miso_viol++;
        if (coreled !== exp_led) led_viol++;
      end else if (jstkss !== 2'b11) ss_viol++;
      prev_state = jstkstate;
      if (coredav) lat_cnt++;
      else lat_cnt = 0;
      coredavin  = coredav && (lat_cnt == LAT) && resp_en[m_ch];
      corexdata  = m_ch ? x1_v : x0_v;
      coreydata  = m_ch ? y1_v : y0_v;
      corebutton = m_ch ? b1_v : b0_v;
      coress     = coredav ? 1'($urandom_range(0, 1)) : 1'b1;
      jstkmiso   = 2'($urandom_range(0, 3));
    end
  end

  // Wait on falling edges for a state of either instance, bounded by budget.
  task automatic wait_state(input bit sel, input logic [2:0] st, input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if ((sel ? o_state : jstkstate) == st) found = 1;
    end
    #1;
    check({tag, "_reach"}, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / directed sequence
  initial begin
    rst_n = 1'b0; jstken = 1'b0; en2 = 1'b1; jstkledreq = 4'b1001;
    resp_en = 2'b11;
    x0_v = 10'h155; y0_v = 10'h0AB; b0_v = 3'b101;
    x1_v = 10'h0F0; y1_v = 10'h2AA; b1_v = 3'b010;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ss", 32'(jstkss), 32'h3);
    check("rst_dav", 32'(coredav), 32'h0);
    check("rst_led", 32'(coreled), 32'h0);
    check("rst_x", 32'(jstkxdata), 32'h0);
    check("rst_y", 32'(jstkydata), 32'h0);
    check("rst_b", 32'(jstkbutton), 32'h0);
    check("rst_upd_to", {28'd0, jstkupd, jstkto}, 32'h0);
    check("rst_ovr_busy", {30'd0, jstkovr, jstkbusy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; jstken = 1'b1;

    // round 1: both channels answer
    wait_state(0, S_DONE, 1300, "r1_ch0");
    check("r1_upd0", 32'(jstkupd), 32'h1);
    check("r1_led0", 32'(coreled), 32'h1);
    check("r1_wait_len", 32'(last_wait), 32'd149);
    check("r1_x0", 32'(jstkxdata[9:0]), 32'h155);
    check("r1_y0", 32'(jstkydata[9:0]), 32'h0AB);
    check("r1_b0", 32'(jstkbutton[2:0]), 32'h5);
    wait_state(0, S_DONE, 400, "r1_ch1");
    check("r1_upd1", 32'(jstkupd), 32'h2);
    check("r1_led1", 32'(coreled), 32'h2);
    check("r1_x1", 32'(jstkxdata[19:10]), 32'h0F0);
    check("r1_y1", 32'(jstkydata[19:10]), 32'h2AA);
    check("r1_b1", 32'(jstkbutton[5:3]), 32'h2);
    check("r1_to", 32'(jstkto), 32'h0);
    wait_state(0, S_IDLE, 10, "r1_idle");
    check("r1_idle_ss", 32'(jstkss), 32'h3);

    // round 2: ch1 never answers; LED request changes mid ch0
    resp_en = 2'b01;
    x1_v = 10'h3C3; y1_v = 10'h111; b1_v = 3'b111;
    wait_state(0, S_WAIT, 1300, "r2_wait0");
    jstkledreq = 4'b0110;
    wait_state(0, S_DONE, 400, "r2_ch0");
    check("r2_upd0", 32'(jstkupd), 32'h1);
    check("r2_led0", 32'(coreled), 32'h1);
    wait_state(0, S_DONE, 400, "r2_ch1");
    check("r2_upd1", 32'(jstkupd), 32'h0);
    check("r2_to", 32'(jstkto), 32'h2);
    check("r2_led1", 32'(coreled), 32'h1);
    check("r2_wait_len", 32'(last_wait), 32'd201);
    check("r2_x1_kept", 32'(jstkxdata[19:10]), 32'h0F0);
    check("r2_y1_kept", 32'(jstkydata[19:10]), 32'h2AA);
    check("r2_b1_kept", 32'(jstkbutton[5:3]), 32'h2);

    // round 3: ch1 answers again and clears its timeout
    resp_en = 2'b11;
    wait_state(0, S_DONE, 1300, "r3_ch0");
    wait_state(0, S_DONE, 400, "r3_ch1");
    check("r3_upd1", 32'(jstkupd), 32'h2);
    check("r3_to", 32'(jstkto), 32'h0);
    check("r3_x1", 32'(jstkxdata[19:10]), 32'h3C3);
    check("r3_b1", 32'(jstkbutton[5:3]), 32'h7);

    // round 4: jstken drops during ch0, ch1 is skipped
    wait_state(0, S_WAIT, 1300, "r4_wait0");
    jstken = 1'b0;
    wait_state(0, S_DONE, 400, "r4_ch0");
    check("r4_upd0", 32'(jstkupd), 32'h1);
    @(negedge clk); #1;
    check("r4_state_idle", 32'(jstkstate), 32'(S_IDLE));
    repeat (50) @(negedge clk);
    #1;
    check("r4_no_ch1", 32'(jstkbusy), 32'h0);
    jstken = 1'b1;

    // overrun on the fast-poll instance
    check("ovr_set", 32'(o_ovr), 32'h1);
    en2 = 1'b0;
    @(negedge clk); #1;
    check("ovr_clear", 32'(o_ovr), 32'h0);
    wait_state(1, S_IDLE, 300, "ovr_idle");
    en2 = 1'b1;
    wait_state(1, S_SETUP, 200, "ovr_resume");
    check("ovr_resume_flag", 32'(o_ovr), 32'h0);

    // reset during ch0 WAIT
    wait_state(0, S_WAIT, 1300, "r5_wait0");
    rst_n = 1'b0;
    #1;
    check("r5_ss", 32'(jstkss), 32'h3);
    check("r5_dav", 32'(coredav), 32'h0);
    check("r5_busy", 32'(jstkbusy), 32'h0);
    check("r5_x", 32'(jstkxdata), 32'h0);
    check("r5_led", 32'(coreled), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_state(0, S_DONE, 1300, "r5_ch0");
    check("r5_upd0", 32'(jstkupd), 32'h1);
    check("r5_x0", 32'(jstkxdata[9:0]), 32'h155);
    wait_state(0, S_IDLE, 400, "r5_idle");

    check("ss_steering", 32'(ss_viol), 32'd0);
    check("miso_steering", 32'(miso_viol), 32'd0);
    check("led_stable", 32'(led_viol), 32'd0);
    check("main_ovr", 32'(jstkovr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
